// File: rtl/disp_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : disp_pkg
//  Purpose  : Shared types and constants for the display scheduler.
//             state_t    - scheduler states
//             BLANK_CODE - digit code the segment decoder renders as blank
//             AN_OFF     - anode pattern with every digit disabled
//             an_decode  - scan index to active-low one-hot anode pattern
//  Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

    typedef enum logic [1:0] {
        SHOW_CREDIT = 2'd0,
        SHOW_MSG    = 2'd1,
        GAP         = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    function automatic logic [3:0] an_decode(input logic [1:0] s);
        logic [3:0] an;
        case (s)
            2'd0:    an = 4'b1110;
            2'd1:    an = 4'b1101;
            2'd2:    an = 4'b1011;
            default: an = 4'b0111;
        endcase
        return an;
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : disp_sched_if
//  Purpose  : Message takeover handshake between a requester and the
//             display scheduler.
//             msg_req  - level request, held until acked
//             msg_bcd  - 4 message codes, stable while msg_req is high
//             msg_ack  - one-cycle pulse when msg_bcd is captured
//             busy     - scheduler is showing a message or the gap frame
//  Revision : 1.0 - initial release
// ============================================================================
interface disp_sched_if;
    logic        msg_req;
    logic [15:0] msg_bcd;
    logic        msg_ack;
    logic        busy;

    modport master (output msg_req, output msg_bcd, input  msg_ack, input  busy);
    modport slave  (input  msg_req, input  msg_bcd, output msg_ack, output busy);
endinterface
`default_nettype wire

// File: rtl/disp_sched_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Purpose  : Digit-slot prescaler and 2-bit scan index for the display.
//             clk, clr     - clock, asynchronous active-high reset
//             tick_o       - last cycle of the current digit slot
//             s_o          - scan index of the current digit slot
//             frame_end_o  - tick on the last slot (S=3) of a frame
//  Revision : 1.0 - initial release
// ============================================================================
module scan_timer #(
    parameter int REFRESH_DIV = 100000
) (
    input  wire logic       clk,
    input  wire logic       clr,
    output logic            tick_o,
    output logic [1:0]      s_o,
    output logic            frame_end_o
);

    localparam int             PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [1:0]    s_q;

    assign tick_o      = (presc_q == PRESC_LAST);
    assign s_o         = s_q;
    assign frame_end_o = tick_o && (s_q == 2'd3);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q <= '0;
            s_q     <= 2'd0;
        end else if (tick_o) begin
            presc_q <= '0;
            s_q     <= s_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/disp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : disp_sched
//  Purpose  : Scheduler for a 4-digit multiplexed 7-segment display. Shows
//             the credit with leading-zero suppression, or a captured
//             message for HOLD_FRAMES full frames followed by one blank frame.
//             clk, clr    - clock, asynchronous active-high reset
//             credit_bcd  - live credit, 4 BCD digits, [3:0] rightmost
//             blank       - forces all anodes off, scan keeps running
//             bus         - message handshake (slave side)
//             AN          - active-low anodes, registered
//             DIG         - code for the enabled digit, 0xF = blank
//  Revision : 1.0 - initial release
// ============================================================================
module disp_sched
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int HOLD_FRAMES = 500
) (
    input  wire logic        clk,
    input  wire logic        clr,
    input  wire logic [15:0] credit_bcd,
    input  wire logic        blank,
    disp_sched_if.slave      bus,
    output logic [3:0]       AN,
    output logic [3:0]       DIG
);

    localparam int             FCW       = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [FCW-1:0] HOLD_LAST = FCW'(HOLD_FRAMES - 1);

    logic           w_tick;
    logic [1:0]     w_s;
    logic           w_frame_end;

    state_t         state_q;
    logic [15:0]    msg_q;
    logic [FCW-1:0] frame_cnt_q;
    logic           skip_q;
    logic           ack_q;
    logic           busy_q;
    logic [3:0]     an_q;
    logic [3:0]     dig_q;

    logic [3:0]     an_d;
    logic [3:0]     dig_d;
    logic [3:0]     w_cred_nib;
    logic           w_cred_lz;

    scan_timer #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan_timer (
        .clk         (clk),
        .clr         (clr),
        .tick_o      (w_tick),
        .s_o         (w_s),
        .frame_end_o (w_frame_end)
    );

    // Digit 0 is never suppressed so a zero credit still reads "0".
    always_comb begin
        w_cred_nib = credit_bcd[{w_s, 2'b00} +: 4];
        case (w_s)
            2'd3:    w_cred_lz = (credit_bcd[15:12] == 4'd0);
            2'd2:    w_cred_lz = (credit_bcd[15:8]  == 8'd0);
            2'd1:    w_cred_lz = (credit_bcd[15:4]  == 12'd0);
            default: w_cred_lz = 1'b0;
        endcase

        case (state_q)
            SHOW_MSG: dig_d = msg_q[{w_s, 2'b00} +: 4];
            GAP:      dig_d = BLANK_CODE;
            default:  dig_d = w_cred_lz ? BLANK_CODE : w_cred_nib;
        endcase

        an_d = (blank || state_q == GAP) ? AN_OFF : an_decode(w_s);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= SHOW_CREDIT;
            msg_q       <= 16'hFFFF;
            frame_cnt_q <= '0;
            skip_q      <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            an_q        <= AN_OFF;
            dig_q       <= BLANK_CODE;
        end else begin
            an_q  <= an_d;
            dig_q <= dig_d;
            ack_q <= 1'b0;
            case (state_q)
                SHOW_CREDIT: begin
                    if (bus.msg_req) begin
                        msg_q       <= bus.msg_bcd;
                        ack_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        frame_cnt_q <= '0;
                        // The frame in progress at capture is partial and is
                        // not counted, unless it ends on this very cycle.
                        skip_q      <= !(w_tick && w_s == 2'd3);
                        state_q     <= SHOW_MSG;
                    end
                end
                SHOW_MSG: begin
                    if (w_frame_end) begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                            if (frame_cnt_q == HOLD_LAST) begin
                                state_q <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    if (w_frame_end) begin
                        state_q <= SHOW_CREDIT;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SHOW_CREDIT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign AN          = an_q;
    assign DIG         = dig_q;
    assign bus.msg_ack = ack_q;
    assign bus.busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_sched
//  Purpose  : Directed self-checking bench for disp_sched with
//             REFRESH_DIV=4, HOLD_FRAMES=2. Edge k counts posedges after
//             reset release; outputs are sampled on the following negedge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_disp_sched;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] credit_bcd;
    logic        blank;
    logic [3:0]  AN;
    logic [3:0]  DIG;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    disp_sched_if u_if ();

    disp_sched #(
        .REFRESH_DIV (4),
        .HOLD_FRAMES (2)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .credit_bcd (credit_bcd),
        .blank      (blank),
        .bus        (u_if),
        .AN         (AN),
        .DIG        (DIG)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr            = 1'b1;
        credit_bcd     = 16'h0125;
        blank          = 1'b0;
        u_if.msg_req   = 1'b0;
        u_if.msg_bcd   = 16'h0000;
        repeat (3) @(negedge clk);

        chk("rst_an",   AN,           16'hF);
        chk("rst_dig",  DIG,          16'hF);
        chk("rst_ack",  u_if.msg_ack, 16'h0);
        chk("rst_busy", u_if.busy,    16'h0);

        clr = 1'b0;
        cyc = 0;

        // Credit 0125: 5,2,1,blank
        adv_to(1);  chk("c125_an0", AN, 16'hE); chk("c125_d0", DIG, 16'h5);
                    chk("c125_ack", u_if.msg_ack, 16'h0);
        adv_to(5);  chk("c125_an1", AN, 16'hD); chk("c125_d1", DIG, 16'h2);
        adv_to(9);  chk("c125_an2", AN, 16'hB); chk("c125_d2", DIG, 16'h1);
        adv_to(13); chk("c125_an3", AN, 16'h7); chk("c125_d3", DIG, 16'hF);

        credit_bcd = 16'h0000;
        adv_to(17); chk("c0_d0", DIG, 16'h0);
        adv_to(21); chk("c0_d1", DIG, 16'hF);
        adv_to(25); chk("c0_d2", DIG, 16'hF);
        adv_to(29); chk("c0_d3", DIG, 16'hF);

        credit_bcd = 16'h1005;
        adv_to(33); chk("c1005_d0", DIG, 16'h5);
        adv_to(37); chk("c1005_d1", DIG, 16'h0);
        adv_to(41); chk("c1005_d2", DIG, 16'h0);
        adv_to(45); chk("c1005_d3", DIG, 16'h1); chk("c1005_an3", AN, 16'h7);

        // Message E0E0 requested mid-frame (S=1), captured at edge 55
        adv_to(54);
        u_if.msg_req = 1'b1;
        u_if.msg_bcd = 16'hE0E0;
        adv_to(55); chk("m1_ack",  u_if.msg_ack, 16'h1); chk("m1_busy", u_if.busy, 16'h1);
        u_if.msg_req = 1'b0;
        adv_to(56); chk("m1_ack_once", u_if.msg_ack, 16'h0);
                    chk("m1_an_56", AN, 16'hD); chk("m1_d_56", DIG, 16'hE);
        adv_to(60); chk("m1_an_60", AN, 16'hB); chk("m1_d_60", DIG, 16'h0);
        adv_to(64); chk("m1_an_64", AN, 16'h7); chk("m1_d_64", DIG, 16'hE);
        adv_to(65); chk("m1_an_65", AN, 16'hE); chk("m1_d_65", DIG, 16'h0);
        adv_to(96); chk("m1_an_96", AN, 16'h7); chk("m1_d_96", DIG, 16'hE);
                    chk("m1_busy_96", u_if.busy, 16'h1);
        adv_to(97); chk("gap1_an_97", AN, 16'hF); chk("gap1_d_97", DIG, 16'hF);
        adv_to(104); chk("gap1_an_104", AN, 16'hF);
        adv_to(112); chk("gap1_an_112", AN, 16'hF); chk("gap1_busy_end", u_if.busy, 16'h0);
        adv_to(113); chk("resume_an", AN, 16'hE); chk("resume_d", DIG, 16'h5);

        // Message 12F3 held continuously; blank pulse during it
        u_if.msg_req = 1'b1;
        u_if.msg_bcd = 16'h12F3;
        adv_to(114); chk("m2_ack", u_if.msg_ack, 16'h1);
        adv_to(115); chk("m2_ack_once", u_if.msg_ack, 16'h0);
        adv_to(130);
        blank = 1'b1;
        adv_to(131); chk("blank_an_131", AN, 16'hF);
        adv_to(135); chk("blank_an_135", AN, 16'hF);
        adv_to(140);
        blank = 1'b0;
        adv_to(141); chk("unblank_an", AN, 16'h7); chk("unblank_d", DIG, 16'h1);
        adv_to(160); chk("m2_an_160", AN, 16'h7); chk("m2_d_160", DIG, 16'h1);
                     chk("m2_busy_160", u_if.busy, 16'h1);
        adv_to(161); chk("gap2_an_161", AN, 16'hF); chk("gap2_d_161", DIG, 16'hF);
        adv_to(176); chk("gap2_an_176", AN, 16'hF); chk("gap2_ack_176", u_if.msg_ack, 16'h0);
        adv_to(177); chk("m3_ack", u_if.msg_ack, 16'h1); chk("m3_busy", u_if.busy, 16'h1);
        u_if.msg_req = 1'b0;
        adv_to(178); chk("m3_an_178", AN, 16'hE); chk("m3_d_178", DIG, 16'h3);
                     chk("m3_ack_once", u_if.msg_ack, 16'h0);

        // Asynchronous reset in the middle of the message
        adv_to(185);
        clr = 1'b1;
        #1;
        chk("aclr_an",   AN,        16'hF);
        chk("aclr_dig",  DIG,       16'hF);
        chk("aclr_busy", u_if.busy, 16'h0);
        @(negedge clk);
        clr = 1'b0;
        cyc = 0;
        adv_to(1);  chk("post_an0", AN, 16'hE); chk("post_d0", DIG, 16'h5);
                    chk("post_busy", u_if.busy, 16'h0);
        adv_to(5);  chk("post_an1", AN, 16'hD); chk("post_d1", DIG, 16'h0);
        adv_to(13); chk("post_an3", AN, 16'h7); chk("post_d3", DIG, 16'h1);
                    chk("post_busy13", u_if.busy, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
